// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester writeback arbiter for the 32 x 64 register file write port (pending mask under RFARB_PENDING_EN)
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [$clog2(NREG)-1:0]  a_addr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [$clog2(NREG)-1:0]  b_addr,
  input  logic [DATA_W-1:0]        b_data,
  output logic [NREG-1:0]          wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [NREG-1:0]          pending
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZREG = AW'(NREG - 1);
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic              full_a, full_b;
  logic [AW-1:0]     addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              rr;
  logic              a_older;
  logic              grant_a, grant_b;
  logic              load_a, load_b;

  // Grant from held state only; same-register writes follow age, otherwise round-robin
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (full_a && !full_b) begin
        grant_a = 1'b1;
      end else if (!full_a && full_b) begin
        grant_b = 1'b1;
      end else if (full_a && full_b) begin
        if (addr_a == addr_b) begin
          grant_a = a_older;
          grant_b = !a_older;
        end else begin
          grant_a = !rr;
          grant_b = rr;
        end
      end
    end
  end

  // Handshakes; writes to the zero register complete but are dropped
  always_comb begin
    a_ready = !full_a || grant_a;
    b_ready = !full_b || grant_b;
    load_a  = a_valid && a_ready && (a_addr != ZREG);
    load_b  = b_valid && b_ready && (b_addr != ZREG);
  end

  // Holding registers, round-robin pointer and age flag
  always_ff @(posedge clk) begin
    if (reset) begin
      full_a  <= 1'b0;
      full_b  <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      data_a  <= '0;
      data_b  <= '0;
      rr      <= 1'b0;
      a_older <= 1'b1;
    end else begin
      if (load_a) begin
        full_a <= 1'b1;
        addr_a <= a_addr;
        data_a <= a_data;
      end else if (grant_a) begin
        full_a <= 1'b0;
      end
      if (load_b) begin
        full_b <= 1'b1;
        addr_b <= b_addr;
        data_b <= b_data;
      end else if (grant_b) begin
        full_b <= 1'b0;
      end
      if (grant_a) begin
        rr <= 1'b1;
      end else if (grant_b) begin
        rr <= 1'b0;
      end
      // A newly loaded entry is younger than one that stays held; A wins ties
      if (load_a && load_b) begin
        a_older <= 1'b1;
      end else if (load_a) begin
        a_older <= !(full_b && !grant_b);
      end else if (load_b) begin
        a_older <= full_a && !grant_a;
      end
    end
  end

  // Register file write port driven by the granted side
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    if (grant_a) begin
      wr_en   = ONE << addr_a;
      wr_data = data_a;
    end else if (grant_b) begin
      wr_en   = ONE << addr_b;
      wr_data = data_b;
    end
  end

  // Pending-write mask for hazard logic
  always_comb begin
`ifdef RFARB_PENDING_EN
    pending = (full_a ? (ONE << addr_a) : '0) | (full_b ? (ONE << addr_b) : '0);
`else
    pending = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_data, b_data;
  logic [31:0] wr_en;
  logic [63:0] wr_data;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    int          acc;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  ent_t        sb[$];
  wr_t         wlog[$];
  logic [63:0] rf[32];

  regfile_wb_arbiter #(.DATA_W(64), .NREG(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: retire against the scoreboard, then record new acceptances
  always @(negedge clk) begin : monitor
    logic [31:0] mask;
    int idx;
    int hit;
    if (reset) begin
      check("rst_wr_en", 64'(wr_en), 64'd0);
      sb.delete();
    end else begin
      mask = '0;
      foreach (sb[i]) mask |= 32'd1 << sb[i].addr;
`ifdef RFARB_PENDING_EN
      check("pending", 64'(pending), 64'(mask));
`else
      check("pending", 64'(pending), 64'd0);
`endif
      check("onehot", 64'($onehot0(wr_en)), 64'd1);
      if (wr_en == 32'd0) begin
        check("idle_data", wr_data, 64'd0);
      end else begin
        idx = 0;
        for (int i = 0; i < 32; i++) if (wr_en[i]) idx = i;
        rf[idx] = wr_data;
        wlog.push_back('{5'(idx), wr_data});
        hit = -1;
        for (int i = 0; i < sb.size(); i++)
          if (hit < 0 && sb[i].addr == 5'(idx)) hit = i;
        if (hit < 0) begin
          check("unexpected_wr", 64'(wr_en), 64'd0);
        end else begin
          check("wr_data", wr_data, sb[hit].data);
          check("latency", 64'((cyc_n - sb[hit].acc) inside {[1:2]}), 64'd1);
          sb.delete(hit);
        end
      end
      if (a_valid && a_ready && a_addr != 5'd31) sb.push_back('{a_addr, a_data, cyc_n});
      if (b_valid && b_ready && b_addr != 5'd31) sb.push_back('{b_addr, b_data, cyc_n});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drive_a(input logic [4:0] ad, input logic [63:0] d);
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic drive_b(input logic [4:0] ad, input logic [63:0] d);
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Stimulus sequence
  initial begin : stim
    int ia;
    int ib;
    logic ha;
    logic hb;
    logic [31:0] exp_pend;
    foreach (rf[i]) rf[i] = 64'd0;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    check("rst_wr_en0", 64'(wr_en), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_pending", 64'(pending), 64'd0);

    // Single A write to X5
    tick();
    drive_a(5'd5, 64'h1111);
    @(negedge clk);
    check("x5_ready", 64'(a_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
`ifdef RFARB_PENDING_EN
    exp_pend = 32'h20;
`else
    exp_pend = 32'h0;
`endif
    check("x5_wr_en", 64'(wr_en), 64'h20);
    check("x5_wr_data", wr_data, 64'h1111);
    check("x5_pending", 64'(pending), 64'(exp_pend));
    check("x5_ready2", 64'(a_ready), 64'd1);
    tick();
    @(negedge clk);
    check("x5_after", 64'(wr_en), 64'd0);
    check("x5_pend_after", 64'(pending), 64'd0);

    // Simultaneous A X1 / B X2 from a fresh round-robin state
    tick();
    pulse_reset();
    wlog.delete();
    drive_a(5'd1, 64'hA);
    drive_b(5'd2, 64'hB);
    tick();
    idle();
    wait_cycles(4);
    check("ab_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("ab_first", 64'(wlog[0].addr), 64'd1);
      check("ab_second", 64'(wlog[1].addr), 64'd2);
    end

    // Both streaming: grants alternate A,B,A,B
    wlog.delete();
    ia = 0;
    ib = 0;
    for (int k = 0; k < 40 && (ia < 8 || ib < 8); k++) begin
      a_valid = (ia < 8);
      a_addr  = 5'(10 + ia);
      a_data  = 64'hA00 + 64'(ia);
      b_valid = (ib < 8);
      b_addr  = 5'(20 + ib);
      b_data  = 64'hB00 + 64'(ib);
      @(negedge clk);
      ha = a_valid && a_ready;
      hb = b_valid && b_ready;
      tick();
      if (ha) ia++;
      if (hb) ib++;
    end
    idle();
    wait_cycles(4);
    check("stream_count", 64'(wlog.size()), 64'd16);
    for (int i = 0; i < wlog.size() && i < 16; i++)
      check("stream_order", 64'(wlog[i].addr),
            64'((i % 2 == 0) ? 10 + i / 2 : 20 + i / 2));

    // Same register X7 with rr pointing at B: A still retires first
    drive_a(5'd0, 64'h5);
    tick();
    idle();
    wait_cycles(3);
    wlog.delete();
    drive_a(5'd7, 64'h1);
    drive_b(5'd7, 64'h2);
    tick();
    idle();
    wait_cycles(4);
    check("x7_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("x7_first", wlog[0].data, 64'h1);
      check("x7_second", wlog[1].data, 64'h2);
    end
    check("x7_final", rf[7], 64'h2);

    // B holds X9 behind an A grant, then A accepts X9: B retires first
    wlog.delete();
    drive_a(5'd8, 64'h8);
    drive_b(5'd9, 64'h3);
    tick();
    b_valid = 1'b0;
    drive_a(5'd9, 64'h4);
    @(negedge clk);
    check("x9_a_ready", 64'(a_ready), 64'd1);
    check("x9_b_ready", 64'(b_ready), 64'd0);
    tick();
    idle();
    wait_cycles(4);
    check("x9_count", 64'(wlog.size()), 64'd3);
    if (wlog.size() == 3) begin
      check("x9_w0", 64'(wlog[0].addr), 64'd8);
      check("x9_w1", wlog[1].data, 64'h3);
      check("x9_w2", wlog[2].data, 64'h4);
    end
    check("x9_final", rf[9], 64'h4);

    // Write to the zero register is accepted and dropped
    wlog.delete();
    drive_a(5'd31, 64'hFFFF);
    @(negedge clk);
    check("x31_ready", 64'(a_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("x31_wr_en", 64'(wr_en), 64'd0);
    check("x31_pending", 64'(pending), 64'd0);
    wait_cycles(3);
    check("x31_count", 64'(wlog.size()), 64'd0);
    check("x31_rf", rf[31], 64'd0);

    // Both holding registers full, then reset for one cycle
    wlog.delete();
    drive_a(5'd3, 64'h33);
    drive_b(5'd4, 64'h44);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_wr_en", 64'(wr_en), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_pending", 64'(pending), 64'd0);
    check("rstmid_a_ready", 64'(a_ready), 64'd1);
    check("rstmid_b_ready", 64'(b_ready), 64'd1);
    wait_cycles(3);
    check("rstmid_count", 64'(wlog.size()), 64'd0);

    // Random traffic with register collisions and zero-register writes
    for (int k = 0; k < 400; k++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      b_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      a_data  = {$urandom, $urandom};
      b_data  = {$urandom, $urandom};
      tick();
    end
    idle();
    wait_cycles(5);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("zero_reg", rf[31], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32 x 64-bit register file. It shares the register file's single write port between two writeback requesters: A is the memory-stage/load return and B is the execute-stage result. Each requester has a one-entry holding register and a valid/ready handshake. Grants alternate round-robin, except that writes to the same register always retire in acceptance order. The block drives the register file's one-hot write-enable vector and write data, and publishes a pending-write mask for hazard logic.

## Interface
Parameters:
- DATA_W, 64, write data width
- NREG, 32, number of architectural registers; index 31 is the zero register

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- a_valid  in  1  requester A presents a write
- a_ready  out  1  A handshake completes when a_valid && a_ready
- a_addr  in  5  A destination register
- a_data  in  64  A write data
- b_valid  in  1  requester B presents a write
- b_ready  out  1  B handshake completes when b_valid && b_ready
- b_addr  in  5  B destination register
- b_data  in  64  B write data
- wr_en  out  32  one-hot write enable to the register file; bit i writes register i
- wr_data  out  64  write data to the register file
- pending  out  32  bit i set while a held, unretired write targets register i

## Operation
- State:
  - holding registers: full_a/addr_a/data_a and full_b/addr_b/data_b
  - round-robin pointer rr: 0 = prefer A, 1 = prefer B
  - age flag a_older
- Grant is computed from registered state only (no combinational path from valid to ready or to wr_en):
  - only one side full: grant that side.
  - both full, addr_a != addr_b: grant the side selected by rr.
  - both full, addr_a == addr_b: grant A if a_older, else B.
- On a grant to side X:
  - wr_en = 1 << addr_X and wr_data = data_X for that cycle; full_X clears at the edge.
  - rr points to the other side.
- With no grant, wr_en = 0 and wr_data = 0.
- Ready: a_ready = !full_a || grant_a; likewise for b_ready. A holding register can therefore drain and refill in the same cycle (full throughput of one write per cycle per side when the other side is idle).
- Acceptance of a write to register 31:
  - The handshake completes, but the holding register is not loaded and no wr_en is ever raised for it.
  - pending[31] is always 0.
  - The register file's zero register stays zero.
- Age tracking:
  - Only A loads (B holding empty or draining this cycle): a_older = 1.
  - Only B loads: a_older = 0.
  - Both load in the same cycle: a_older = 1, since A is program-older by convention.
  - One side loads while the other remains held: the held side is older.
- pending = (full_a ? 1 << addr_a : 0) | (full_b ? 1 << addr_b : 0).

## Timing
- Reset values: full_a = full_b = 0, rr = 0, a_older = 1. Outputs after reset: a_ready = b_ready = 1, wr_en = 0, wr_data = 0, pending = 0.
- Latency: a handshake at edge N produces wr_en at cycle N+1 at the earliest. A write held behind the other side retires by cycle N+2.
- At most one bit of wr_en is set in any cycle.
- Reset asserted mid-operation:
  - held writes are discarded without being written; wr_en = 0 in the reset cycle.
  - handshakes occurring during reset are ignored.
- Both sides full and no grant possible never occurs; a full side is granted within 2 cycles.

## Configuration
- RFARB_PENDING_EN defined: the pending mask is generated as described above.
- RFARB_PENDING_EN undefined: pending is tied to 32'b0. Arbitration, age ordering and the handshakes are unchanged.

## Test plan
- Reset, then A writes X5=0x1111 at cycle 1 -> wr_en=0x0000_0020, wr_data=0x1111 at cycle 2; pending[5]=1 during cycle 2 only; a_ready stays 1 throughout.
- A (X1=0xA) and B (X2=0xB) handshake at the same edge -> X1 written at cycle N+1 (rr=0), X2 at N+2; with both streaming continuously, grants alternate A,B,A,B.
- A (X7=0x1) and B (X7=0x2) handshake at the same edge with rr=1 -> A retires first despite rr, then B; register 7 ends at 0x2.
- B holds X9=0x3 and is blocked by an A grant, then A accepts X9=0x4 -> B's 0x3 retires before A's 0x4.
- A writes X31=0xFFFF -> handshake completes, wr_en stays 0, pending=0, and the zero register still reads 0.
- Both holding registers full, reset pulsed for 1 cycle -> no wr_en afterwards, pending=0, both ready=1.
